// File: rtl/cache_axi_bridge_mo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_axi_bridge_mo: I/D-cache miss ports to one AXI3 master, one read   |
// | outstanding per requester, one-entry write buffer with line hazard check.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cache_axi_bridge_mo #(
    parameter int LINE_WORDS = 4,
    parameter int OFF_BITS   = $clog2(LINE_WORDS * 4)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       inst_rd_req,
    input  logic [2:0]                 inst_rd_type,
    input  logic [31:0]                inst_rd_addr,
    output logic                       inst_rd_rdy,
    output logic                       inst_ret_valid,
    output logic [LINE_WORDS*32-1:0]   inst_ret_data,
    input  logic                       data_rd_req,
    input  logic [2:0]                 data_rd_type,
    input  logic [31:0]                data_rd_addr,
    output logic                       data_rd_rdy,
    output logic                       data_ret_valid,
    output logic [LINE_WORDS*32-1:0]   data_ret_data,
    input  logic                       data_wr_req,
    input  logic [2:0]                 data_wr_type,
    input  logic [31:0]                data_wr_addr,
    input  logic [3:0]                 data_wr_wstrb,
    input  logic [LINE_WORDS*32-1:0]   data_wr_data,
    output logic                       data_wr_rdy,
    output logic [3:0]                 axi_arid,
    output logic [31:0]                axi_araddr,
    output logic [7:0]                 axi_arlen,
    output logic [2:0]                 axi_arsize,
    output logic [1:0]                 axi_arburst,
    output logic [1:0]                 axi_arlock,
    output logic [3:0]                 axi_arcache,
    output logic [2:0]                 axi_arprot,
    output logic                       axi_arvalid,
    input  logic                       axi_arready,
    input  logic [3:0]                 axi_rid,
    input  logic [31:0]                axi_rdata,
    input  logic [1:0]                 axi_rresp,
    input  logic                       axi_rlast,
    input  logic                       axi_rvalid,
    output logic                       axi_rready,
    output logic [3:0]                 axi_awid,
    output logic [31:0]                axi_awaddr,
    output logic [7:0]                 axi_awlen,
    output logic [2:0]                 axi_awsize,
    output logic [1:0]                 axi_awburst,
    output logic [1:0]                 axi_awlock,
    output logic [3:0]                 axi_awcache,
    output logic [2:0]                 axi_awprot,
    output logic                       axi_awvalid,
    input  logic                       axi_awready,
    output logic [3:0]                 axi_wid,
    output logic [31:0]                axi_wdata,
    output logic [3:0]                 axi_wstrb,
    output logic                       axi_wlast,
    output logic                       axi_wvalid,
    input  logic                       axi_wready,
    input  logic [3:0]                 axi_bid,
    input  logic [1:0]                 axi_bresp,
    input  logic                       axi_bvalid,
    output logic                       axi_bready
);

    localparam int         CNT_W       = $clog2(LINE_WORDS);
    localparam logic [2:0] c_type_line = 3'b100;

    typedef enum logic [0:0] {AR_IDLE = 1'b0, AR_SEND = 1'b1} ar_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} w_state_t;

    function automatic logic [7:0] f_len(input logic [2:0] typ);
        return (typ == c_type_line) ? 8'(LINE_WORDS - 1) : 8'd0;
    endfunction

    // read side: index 0 = inst (ID 0), index 1 = data (ID 1)
    ar_state_t                    r_ar_state;
    logic [1:0]                   r_busy;
    logic [31:0]                  r_araddr;
    logic [3:0]                   r_arid;
    logic [7:0]                   r_arlen;
    logic [31:OFF_BITS]           r_drd_line;
    logic [CNT_W-1:0]             r_rcnt [2];
    logic [LINE_WORDS-1:0][31:0]  r_rbuf [2];
    logic [1:0]                   r_ret_valid;

    w_state_t                     r_w_state;
    logic                         r_wb_valid;
    logic [31:0]                  r_wb_addr;
    logic [7:0]                   r_wlen;
    logic [LINE_WORDS-1:0][31:0]  r_wb_data;
    logic [3:0]                   r_wstrb;
    logic [CNT_W-1:0]             r_wcnt;

    logic w_raw_inst, w_raw_data, w_data_rd_acc, w_inst_rd_acc, w_wr_acc, w_rid;
    logic w_unused;

    assign w_raw_inst = r_wb_valid && (inst_rd_addr[31:OFF_BITS] == r_wb_addr[31:OFF_BITS]);
    assign w_raw_data = r_wb_valid && (data_rd_addr[31:OFF_BITS] == r_wb_addr[31:OFF_BITS]);

    assign data_rd_rdy   = (r_ar_state == AR_IDLE) && !r_busy[1] && !w_raw_data;
    assign w_data_rd_acc = data_rd_req && data_rd_rdy;
    assign inst_rd_rdy   = (r_ar_state == AR_IDLE) && !r_busy[0] && !w_raw_inst && !w_data_rd_acc;
    assign w_inst_rd_acc = inst_rd_req && inst_rd_rdy;

    assign data_wr_rdy = (r_w_state == W_IDLE) &&
                         !(r_busy[1] && (r_drd_line == data_wr_addr[31:OFF_BITS]));
    assign w_wr_acc    = data_wr_req && data_wr_rdy;

    assign w_rid    = axi_rid[0];
    assign w_unused = ^{axi_rid[3:1], axi_rresp, axi_bid, axi_bresp};

    assign axi_arid    = r_arid;
    assign axi_araddr  = r_araddr;
    assign axi_arlen   = r_arlen;
    assign axi_arsize  = 3'd2;
    assign axi_arburst = 2'b01;
    assign axi_arlock  = 2'b00;
    assign axi_arcache = 4'd0;
    assign axi_arprot  = 3'd0;
    assign axi_arvalid = (r_ar_state == AR_SEND);
    assign axi_rready  = 1'b1;

    assign inst_ret_valid = r_ret_valid[0];
    assign data_ret_valid = r_ret_valid[1];
    assign inst_ret_data  = r_rbuf[0];
    assign data_ret_data  = r_rbuf[1];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ar_state  <= AR_IDLE;
            r_busy      <= 2'b00;
            r_araddr    <= 32'd0;
            r_arid      <= 4'd0;
            r_arlen     <= 8'd0;
            r_drd_line  <= '0;
            r_rcnt[0]   <= '0;
            r_rcnt[1]   <= '0;
            r_rbuf[0]   <= '0;
            r_rbuf[1]   <= '0;
            r_ret_valid <= 2'b00;
        end else begin
            r_ret_valid <= 2'b00;
            if (axi_rvalid) begin
                r_rbuf[w_rid][r_rcnt[w_rid]] <= axi_rdata;
                if (axi_rlast) begin
                    r_rcnt[w_rid]      <= '0;
                    r_busy[w_rid]      <= 1'b0;
                    r_ret_valid[w_rid] <= 1'b1;
                end else begin
                    r_rcnt[w_rid] <= r_rcnt[w_rid] + 1'b1;
                end
            end
            case (r_ar_state)
                AR_IDLE: begin
                    if (w_data_rd_acc) begin
                        r_arid     <= 4'd1;
                        r_araddr   <= data_rd_addr;
                        r_arlen    <= f_len(data_rd_type);
                        r_drd_line <= data_rd_addr[31:OFF_BITS];
                        r_busy[1]  <= 1'b1;
                        r_ar_state <= AR_SEND;
                    end else if (w_inst_rd_acc) begin
                        r_arid     <= 4'd0;
                        r_araddr   <= inst_rd_addr;
                        r_arlen    <= f_len(inst_rd_type);
                        r_busy[0]  <= 1'b1;
                        r_ar_state <= AR_SEND;
                    end
                end
                AR_SEND: if (axi_arready) r_ar_state <= AR_IDLE;
                default: r_ar_state <= AR_IDLE;
            endcase
        end
    end

    assign axi_awid    = 4'd1;
    assign axi_awaddr  = r_wb_addr;
    assign axi_awlen   = r_wlen;
    assign axi_awsize  = 3'd2;
    assign axi_awburst = 2'b01;
    assign axi_awlock  = 2'b00;
    assign axi_awcache = 4'd0;
    assign axi_awprot  = 3'd0;
    assign axi_awvalid = (r_w_state == W_AW);
    assign axi_wid     = 4'd1;
    // data word is picked straight from the buffer so beats can go back to back
    assign axi_wdata   = r_wb_data[r_wcnt];
    assign axi_wstrb   = r_wstrb;
    assign axi_wvalid  = (r_w_state == W_DATA);
    assign axi_wlast   = (r_w_state == W_DATA) && (8'(r_wcnt) == r_wlen);
    assign axi_bready  = (r_w_state == W_RESP);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_w_state  <= W_IDLE;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= 32'd0;
            r_wlen     <= 8'd0;
            r_wb_data  <= '0;
            r_wstrb    <= 4'd0;
            r_wcnt     <= '0;
        end else begin
            case (r_w_state)
                W_IDLE: begin
                    if (w_wr_acc) begin
                        r_wb_valid <= 1'b1;
                        r_wb_addr  <= data_wr_addr;
                        r_wlen     <= f_len(data_wr_type);
                        r_wb_data  <= data_wr_data;
                        r_wstrb    <= (data_wr_type == c_type_line) ? 4'hF : data_wr_wstrb;
                        r_w_state  <= W_AW;
                    end
                end
                W_AW: if (axi_awready) r_w_state <= W_DATA;
                W_DATA: begin
                    if (axi_wready) begin
                        r_wcnt <= r_wcnt + 1'b1;
                        if (axi_wlast) r_w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (axi_bvalid) begin
                        r_wb_valid <= 1'b0;
                        r_wcnt     <= '0;
                        r_w_state  <= W_IDLE;
                    end
                end
                default: r_w_state <= W_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/cache_axi_bridge_mo.md
Name: cache_axi_bridge_mo

Overview:
- Parametrised bridge between the I-cache/D-cache miss interfaces and one AXI3 master port; successor of the single-outstanding cache/AXI adapter.
- Allows one outstanding read per requester: inst uses ID 0 and data uses ID 1, and their R beats may interleave.
- Has a one-entry write buffer. It replaces global read/write serialisation with line-address hazard checks, so only same-line accesses stall.
- Sits between the cache pair and the AXI crossbar/SRAM bridge.

Parameters:
- LINE_WORDS, 4, words per cache line (power of 2, 2..16); burst length for line transfers.
- OFF_BITS, $clog2(LINE_WORDS*4), byte-offset bits of a line; derived, not overridden.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- inst_rd_req / inst_rd_type / inst_rd_addr  in  1/3/32  I-cache read request. Type 3'b010 = single word, 3'b100 = line.
- inst_rd_rdy  out  1  I-cache read request accepted when req&&rdy
- inst_ret_valid / inst_ret_data  out  1/LINE_WORDS*32  refill done pulse and line data (word0 in bits [31:0])
- data_rd_req / data_rd_type / data_rd_addr / data_rd_rdy  in/in/in/out  1/3/32/1  D-cache read, same rules as inst
- data_ret_valid / data_ret_data  out  1/LINE_WORDS*32  D-cache refill done pulse and line data
- data_wr_req / data_wr_type / data_wr_addr  in  1/3/32  D-cache write request
- data_wr_wstrb / data_wr_data  in  4/LINE_WORDS*32  write strobes and write data
- data_wr_rdy  out  1  D-cache write request accepted when req&&rdy
- axi_ar{id,addr,len,size,burst,lock,cache,prot,valid}  out  4,32,8,3,2,2,4,3,1;  axi_arready  in  1
- axi_r{id,data,resp,last,valid}  in  4,32,2,1,1;  axi_rready  out  1
- axi_aw{id,addr,len,size,burst,lock,cache,prot,valid}  out  4,32,8,3,2,2,4,3,1;  axi_awready  in  1
- axi_w{id,data,strb,last,valid}  out  4,32,4,1,1;  axi_wready  in  1
- axi_b{id,resp,valid}  in  4,2,1;  axi_bready  out  1

Behaviour:
- Constants: ar/awsize=2, burst=INCR(1), lock/cache/prot=0, awid=wid=1. rresp/bresp are ignored. axi_rready=1 always.
- Reset: all FSMs idle, busy/wb_valid=0, counters=0, ret_data=0. arvalid, awvalid, wvalid, wlast, bready and ret_valid are 0. The rdy outputs are high from the first cycle after reset.
- len rule: type 3'b100 gives len=LINE_WORDS-1; any other type gives len=0.
- raw_hit(x): wb_valid && x[31:OFF_BITS]==wb_addr[31:OFF_BITS].
- AR FSM, states AR_IDLE and AR_SEND:
  - data_rd_rdy = AR_IDLE && !data_busy && !raw_hit(data_rd_addr).
  - inst_rd_rdy = AR_IDLE && !inst_busy && !raw_hit(inst_rd_addr) && !(data_rd_req&&data_rd_rdy). Data has priority.
  - On accept: latch addr/id/len, set the requester's busy bit, go to AR_SEND.
  - arvalid=1 in AR_SEND; it is held with stable payload until arready, then AR_IDLE.
- R path, one beat counter and line buffer per ID:
  - Each rvalid beat writes buffer word [cnt[rid]] and increments that counter.
  - On rlast: the counter clears, busy[rid] clears, and the matching ret_valid pulses for exactly 1 cycle on the next cycle. ret_data is stable from then until the next beat of that ID.
  - Single-word reads land in word 0.
- W FSM, states W_IDLE → W_AW → W_DATA → W_RESP:
  - data_wr_rdy = W_IDLE && !(data_busy && data line addr == data_wr_addr line).
  - On accept: set wb_valid and latch addr, len and data. wstrb latches data_wr_wstrb for type 3'b010 and 4'hF for a line. Single-word writes send data word 0.
  - awvalid=1 in W_AW until awready.
  - In W_DATA, wvalid=1 and wdata=buffer word[wcnt] combinationally (no bubble). wlast = (wcnt==len). wcnt increments per handshake.
  - The last handshake moves to W_RESP with bready=1. On bvalid, go to W_IDLE and clear wb_valid and wcnt.
- Same-cycle cases:
  - A write accept blocks a same-line read only from the next cycle. The cache must not issue a same-line read in the same cycle.
  - A B handshake and a same-line read request in the same cycle: the read is accepted on the next cycle.
  - rlast for ID0 and an accept for ID1 in the same cycle are independent.
- Reset mid-transaction abandons all state; the AXI slave is reset with it.

Test Plan:
- Inst line read at 0x1FC0_0000, LINE_WORDS=4 → arid=0, arlen=3, arvalid the cycle after accept. Beats A0..A3 give ret_data={A3,A2,A1,A0} and a 1-cycle inst_ret_valid one cycle after rlast.
- Inst and data requests in the same cycle → data accepted first (arid=1). Inst is accepted next cycle after the AR handshake. Interleaved R beats of IDs 0/1 reassemble both lines correctly.
- Line write to 0x0000_1040 with slave wready toggling → 4 W beats, wstrb=F, wlast only on beat 3. Data is in word order. bready is high only in W_RESP.
- Write to 0x1040 pending and data read of 0x1048 → data_rd_rdy=0 until the cycle after bvalid. A read of 0x2000 is accepted immediately.
- Single-word write type 010 with wstrb=4'b0011 → awlen=0, one beat with wstrb=0011 and wlast=1.
- resetn low during W_DATA → next cycle all valids are 0 and the rdy outputs are 1.
- LINE_WORDS=8 → arlen=7 and ret_data is 256 bits.
